// File: rtl/rll_key_pkg.sv
// Shared types and helpers for the RLL32 key loader: FSM states, byte width
// and the running XOR checksum step.
package rll_key_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CHK  = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_e;

    localparam int BYTE_W = 8;

    function automatic logic [BYTE_W-1:0] xsum_next(
        input logic [BYTE_W-1:0] xsum,
        input logic [BYTE_W-1:0] b
    );
        return xsum ^ b;
    endfunction

endpackage

// File: rtl/rll_key_loader.sv
// Receives a key as an LSB-first byte stream, verifies a trailing XOR checksum and
// only then drives the key bus of the locked netlist; otherwise the bus shows DECOY.
module rll_key_loader
    import rll_key_pkg::*;
#(
    parameter int               KEY_W = 32,
    parameter logic [KEY_W-1:0] DECOY = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic [KEY_W-1:0]  key_out,
    output logic              key_valid,
    output logic              busy,
    output logic              err
);

    localparam int NB = KEY_W / BYTE_W;
    localparam int CW = $clog2(NB) + 1;

    if (KEY_W % BYTE_W != 0 || KEY_W <= 0) begin : g_bad_key_w
        $error("rll_key_loader: KEY_W must be a positive multiple of 8");
    end

    state_e            state_q, state_d;
    logic [KEY_W-1:0]  shreg_q;
    logic [BYTE_W-1:0] xsum_q;
    logic [CW-1:0]     cnt_q;
    logic [KEY_W-1:0]  key_q;
    logic              key_valid_q;
    logic              err_q;
    logic              beat;
    logic              last_beat;
    logic              sum_ok;

    // Handshake: a byte transfers on a rising edge where s_valid && s_ready.
    // s_ready is a pure decode of the registered state, so it never depends on s_valid.
    assign s_ready   = (state_q == LOAD) || (state_q == CHK);
    assign busy      = s_ready;
    assign beat      = s_valid && s_ready;
    assign last_beat = (cnt_q == CW'(NB - 1));
    assign sum_ok    = (s_data == xsum_q);

    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = LOAD;
        end else begin
            case (state_q)
                LOAD:    if (beat && last_beat) state_d = CHK;
                CHK:     if (beat) state_d = sum_ok ? DONE : ERR;
                default: state_d = state_q;
            endcase
        end
    end

    // start takes priority over any beat on the same edge, so that byte is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q     <= '0;
            xsum_q      <= '0;
            cnt_q       <= '0;
            key_q       <= DECOY;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (start) begin
            shreg_q     <= '0;
            xsum_q      <= '0;
            cnt_q       <= '0;
            key_q       <= DECOY;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else if (beat && state_q == LOAD) begin
            for (int i = 0; i < NB; i++) begin
                if (cnt_q == CW'(i)) shreg_q[i*BYTE_W +: BYTE_W] <= s_data;
            end
            xsum_q <= xsum_next(xsum_q, s_data);
            cnt_q  <= cnt_q + CW'(1);
        end else if (beat && state_q == CHK) begin
            if (sum_ok) begin
                key_q       <= shreg_q;
                key_valid_q <= 1'b1;
            end else begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rll_key_loader.sv
// Directed bench for rll_key_loader: good/bad checksum, stalls, restart,
// start/beat collision, reload from DONE and reset during CHK.
module tb_rll_key_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic [31:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;

  int checks = 0;
  int failures = 0;

  rll_key_loader #(.KEY_W(32), .DECOY(32'h0)) dut (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .key_out(key_out), .key_valid(key_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [7:0] b);
    s_valid = 1'b1; s_data = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (key_out !== 32'h0) begin failures++; $display("FAIL reset_key got=%h exp=%h", key_out, 32'h0); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_kv got=%b exp=0", key_valid); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
  endtask

  task automatic test_good_key();
    logic [7:0] bytes_a[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pulse_start();
    checks++; if (busy !== 1'b1 || s_ready !== 1'b1) begin failures++; $display("FAIL t1_load_busy got=%b%b exp=11", busy, s_ready); end
    for (int i = 0; i < 4; i++) begin
      send_beat(bytes_a[i]);
      checks++; if (key_out !== 32'h0) begin failures++; $display("FAIL t1_partial_key beat=%0d got=%h exp=%h", i, key_out, 32'h0); end
    end
    checks++; if (busy !== 1'b1 || s_ready !== 1'b1 || key_valid !== 1'b0) begin failures++; $display("FAIL t1_chk_state got=busy%b rdy%b kv%b exp=1,1,0", busy, s_ready, key_valid); end
    send_beat(8'h22);
    checks++; if (key_out !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_key got=%h exp=%h", key_out, 32'hDEADBEEF); end
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL t1_kv got=%b exp=1", key_valid); end
    checks++; if (err !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL t1_done got=err%b busy%b rdy%b exp=0,0,0", err, busy, s_ready); end
    send_beat(8'h55);
    checks++; if (key_out !== 32'hDEADBEEF || key_valid !== 1'b1) begin failures++; $display("FAIL t1_hold got=%h/%b exp=%h/1", key_out, key_valid, 32'hDEADBEEF); end
  endtask

  task automatic test_reload_from_done();
    pulse_start();
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL t5_kv got=%b exp=0", key_valid); end
    checks++; if (key_out !== 32'h0) begin failures++; $display("FAIL t5_key got=%h exp=%h", key_out, 32'h0); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL t5_busy got=%b exp=1", busy); end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] bytes_a[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 4; i++) send_beat(bytes_a[i]);
    send_beat(8'h23);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL t2_err got=%b exp=1", err); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL t2_kv got=%b exp=0", key_valid); end
    checks++; if (key_out !== 32'h0) begin failures++; $display("FAIL t2_key got=%h exp=%h", key_out, 32'h0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL t2_busy got=%b exp=0", busy); end
    tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL t2_sticky got=%b exp=1", err); end
    pulse_start();
    checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL t2_clear got=err%b busy%b exp=0,1", err, busy); end
  endtask

  task automatic test_stalls();
    logic [7:0] bytes_a[5] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    int decoy_bad = 0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = bytes_a[i];
      tick();
      if (i < 4 && key_out !== 32'h0) decoy_bad++;
      s_valid = 1'b0; s_data = 8'hFF;
      tick();
      if (i < 4 && (key_out !== 32'h0 || key_valid !== 1'b0)) decoy_bad++;
    end
    checks++; if (decoy_bad !== 0) begin failures++; $display("FAIL t3_decoy got=%0d leaks exp=0", decoy_bad); end
    checks++; if (key_out !== 32'hDEADBEEF || key_valid !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL t3_key got=%h/%b/%b exp=%h/1/0", key_out, key_valid, err, 32'hDEADBEEF); end
  endtask

  task automatic test_restart_mid_load();
    logic [7:0] bytes_b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start();
    send_beat(8'hEF);
    send_beat(8'hBE);
    pulse_start();
    for (int i = 0; i < 4; i++) send_beat(bytes_b[i]);
    send_beat(8'h44);
    checks++; if (key_out !== 32'h44332211 || key_valid !== 1'b1) begin failures++; $display("FAIL t4_key got=%h/%b exp=%h/1", key_out, key_valid, 32'h44332211); end
  endtask

  task automatic test_start_beat_collision();
    logic [7:0] bytes_b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    pulse_start();
    send_beat(8'h01);
    send_beat(8'h02);
    // start and a valid byte together: byte must be dropped
    start = 1'b1; s_valid = 1'b1; s_data = 8'hAA;
    tick();
    start = 1'b0; s_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(bytes_b[i]);
    send_beat(8'h44);
    checks++; if (key_out !== 32'h44332211 || key_valid !== 1'b1) begin failures++; $display("FAIL collide_key got=%h/%b exp=%h/1", key_out, key_valid, 32'h44332211); end
  endtask

  task automatic test_back_to_back_latency();
    logic [7:0] bytes_b[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    int cyc = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      s_data = bytes_b[i];
      checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL lat_early cyc=%0d got=%b exp=0", cyc, key_valid); end
      tick();
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (key_valid !== 1'b1 || cyc !== 6) begin failures++; $display("FAIL lat_kv got=%b at cyc=%0d exp=1 at 6", key_valid, cyc); end
  endtask

  task automatic test_reset_mid_chk();
    logic [7:0] bytes_a[4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pulse_start();
    for (int i = 0; i < 4; i++) send_beat(bytes_a[i]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (key_out !== 32'h0 || key_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL t6_out got=%h/%b/%b exp=%h/0/0", key_out, key_valid, err, 32'h0); end
    checks++; if (busy !== 1'b0 || s_ready !== 1'b0) begin failures++; $display("FAIL t6_idle got=busy%b rdy%b exp=0,0", busy, s_ready); end
    send_beat(8'h22);
    checks++; if (key_valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || key_out !== 32'h0) begin failures++; $display("FAIL t6_ignore got=kv%b err%b busy%b key%h exp=0,0,0,0", key_valid, err, busy, key_out); end
  endtask

  initial begin
    test_reset();
    test_good_key();
    test_reload_from_done();
    test_bad_checksum();
    test_stalls();
    test_restart_mid_load();
    test_start_beat_collision();
    test_back_to_back_latency();
    test_reset_mid_chk();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
